// File: rtl/kbd_textbuf_arbiter.sv
// Single-port text buffer arbiter: keyboard writes, CPU load/store and VGA reads share one RAM,
// plus a keyboard-triggered line clear that runs in the gaps between CPU/VGA accesses.
module kbd_textbuf_arbiter #(
  parameter int unsigned ADDR_W   = 10,
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned LINE_LEN = 64,
  parameter logic [DATA_W-1:0] CLR_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              kb_req,
  input  logic              kb_clr,
  input  logic [ADDR_W-1:0] kb_addr,
  input  logic [DATA_W-1:0] kb_wdata,
  output logic              kb_gnt,
  output logic              kb_busy,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              vga_req,
  input  logic [ADDR_W-1:0] vga_addr,
  output logic              vga_gnt,
  output logic              vga_rvalid,
  output logic [DATA_W-1:0] vga_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int unsigned CNT_W = (LINE_LEN > 1) ? $clog2(LINE_LEN) : 1;
  localparam logic [ADDR_W-1:0] LINE_MASK = ADDR_W'(LINE_LEN - 1);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(LINE_LEN - 1);

  typedef enum logic {StIdle, StClear} state_e;

  state_e            state;
  logic              rr;            // 0: CPU wins a tie, 1: VGA wins a tie
  logic [ADDR_W-1:0] base;
  logic [CNT_W-1:0]  cnt;
  logic              cpu_rvalid_q;
  logic              vga_rvalid_q;

  logic cpu_win, vga_win, clr_wr;

  always_comb begin
    cpu_win   = cpu_req & (~vga_req | ~rr);
    vga_win   = vga_req & (~cpu_req | rr);
    kb_gnt    = 1'b0;
    kb_busy   = 1'b0;
    cpu_gnt   = 1'b0;
    vga_gnt   = 1'b0;
    clr_wr    = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    // Outputs are forced quiet while reset is held so an aborted clear writes nothing.
    if (!rst) begin
      if (state == StIdle && kb_req) begin
        kb_gnt  = 1'b1;
        kb_busy = kb_clr;
        if (!kb_clr) begin
          mem_en    = 1'b1;
          mem_we    = 1'b1;
          mem_addr  = kb_addr;
          mem_wdata = kb_wdata;
        end
      end else if (cpu_win) begin
        cpu_gnt   = 1'b1;
        mem_en    = 1'b1;
        mem_we    = cpu_we;
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
      end else if (vga_win) begin
        vga_gnt  = 1'b1;
        mem_en   = 1'b1;
        mem_addr = vga_addr;
      end else if (state == StClear) begin
        clr_wr    = 1'b1;
        mem_en    = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = base | ADDR_W'(cnt);
        mem_wdata = CLR_VAL;
      end
      if (state == StClear) begin
        kb_busy = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= StIdle;
      rr           <= 1'b0;
      base         <= '0;
      cnt          <= '0;
      cpu_rvalid_q <= 1'b0;
      vga_rvalid_q <= 1'b0;
    end else begin
      cpu_rvalid_q <= cpu_gnt & ~cpu_we;
      vga_rvalid_q <= vga_gnt;
      if (cpu_gnt) begin
        rr <= 1'b1;
      end else if (vga_gnt) begin
        rr <= 1'b0;
      end
      case (state)
        StIdle: begin
          if (kb_gnt && kb_clr) begin
            base  <= kb_addr & ~LINE_MASK;
            cnt   <= '0;
            state <= StClear;
          end
        end
        StClear: begin
          if (clr_wr) begin
            cnt <= cnt + 1'b1;
            if (cnt == CNT_LAST) begin
              state <= StIdle;
            end
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

  // A read granted just before reset must not report valid data during reset.
  assign cpu_rvalid = cpu_rvalid_q & ~rst;
  assign vga_rvalid = vga_rvalid_q & ~rst;
  assign cpu_rdata  = mem_rdata;
  assign vga_rdata  = mem_rdata;

endmodule

// File: tb/tb_kbd_textbuf_arbiter.sv
// Directed bench for kbd_textbuf_arbiter: a vector table for single-cycle arbitration plus
// hand-written sequences for line clear, clear pre-emption and reset mid-clear.
module tb_kbd_textbuf_arbiter;

  logic       clk, rst;
  logic       kb_req, kb_clr, kb_gnt, kb_busy;
  logic [9:0] kb_addr;
  logic [7:0] kb_wdata;
  logic       cpu_req, cpu_we, cpu_gnt, cpu_rvalid;
  logic [9:0] cpu_addr;
  logic [7:0] cpu_wdata, cpu_rdata;
  logic       vga_req, vga_gnt, vga_rvalid;
  logic [9:0] vga_addr;
  logic [7:0] vga_rdata;
  logic       mem_en, mem_we;
  logic [9:0] mem_addr;
  logic [7:0] mem_wdata, mem_rdata;

  int n_checks = 0;
  int n_err    = 0;

  kbd_textbuf_arbiter dut (
    .clk(clk), .rst(rst),
    .kb_req(kb_req), .kb_clr(kb_clr), .kb_addr(kb_addr), .kb_wdata(kb_wdata),
    .kb_gnt(kb_gnt), .kb_busy(kb_busy),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .vga_req(vga_req), .vga_addr(vga_addr), .vga_gnt(vga_gnt),
    .vga_rvalid(vga_rvalid), .vga_rdata(vga_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous RAM with one-cycle read latency; ram_init reloads a known pattern.
  logic [7:0] ram [1024];
  logic       ram_init;
  always @(posedge clk) begin
    if (ram_init) begin
      for (int i = 0; i < 1024; i++) ram[i] <= 8'(i) ^ 8'h5A;
    end else if (mem_en && mem_we) begin
      ram[mem_addr] <= mem_wdata;
    end
    if (mem_en && !mem_we) mem_rdata <= ram[mem_addr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic quiet();
    kb_req = 0; kb_clr = 0; kb_addr = '0; kb_wdata = '0;
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    vga_req = 0; vga_addr = '0;
  endtask

  typedef struct {
    logic       kq;  logic [9:0] ka;  logic [7:0] kd;
    logic       cq;  logic       cw;  logic [9:0] ca; logic [7:0] cd;
    logic       vq;  logic [9:0] va;
    logic       ekb, ecpu, evga, een, ewe;
    logic [9:0] eaddr; logic [7:0] ewd;
    logic       ecrv, evrv; logic [7:0] erd;
  } vec_t;

  function automatic vec_t mk(
      logic kq, logic [9:0] ka, logic [7:0] kd,
      logic cq, logic cw, logic [9:0] ca, logic [7:0] cd,
      logic vq, logic [9:0] va,
      logic ekb, logic ecpu, logic evga, logic een, logic ewe,
      logic [9:0] eaddr, logic [7:0] ewd, logic ecrv, logic evrv, logic [7:0] erd);
    vec_t r;
    r.kq = kq; r.ka = ka; r.kd = kd; r.cq = cq; r.cw = cw; r.ca = ca; r.cd = cd;
    r.vq = vq; r.va = va; r.ekb = ekb; r.ecpu = ecpu; r.evga = evga; r.een = een;
    r.ewe = ewe; r.eaddr = eaddr; r.ewd = ewd; r.ecrv = ecrv; r.evrv = evrv; r.erd = erd;
    return r;
  endfunction

  vec_t vecs [12];
  int   busy_cycles;

  initial begin
    // RAM pattern is addr[7:0]^0x5A, so e.g. 0x010 reads 0x4A.
    vecs[0]  = mk(1,10'h041,8'h16, 0,0,10'h000,8'h00, 0,10'h000, 1,0,0,1,1,10'h041,8'h16, 0,0,8'h00);
    vecs[1]  = mk(0,10'h000,8'h00, 1,0,10'h010,8'h00, 1,10'h020, 0,1,0,1,0,10'h010,8'h00, 0,0,8'h00);
    vecs[2]  = mk(0,10'h000,8'h00, 1,0,10'h011,8'h00, 1,10'h020, 0,0,1,1,0,10'h020,8'h00, 1,0,8'h4A);
    vecs[3]  = mk(0,10'h000,8'h00, 1,0,10'h011,8'h00, 1,10'h021, 0,1,0,1,0,10'h011,8'h00, 0,1,8'h7A);
    vecs[4]  = mk(0,10'h000,8'h00, 1,0,10'h012,8'h00, 1,10'h021, 0,0,1,1,0,10'h021,8'h00, 1,0,8'h4B);
    vecs[5]  = mk(1,10'h042,8'h33, 1,0,10'h013,8'h00, 1,10'h022, 1,0,0,1,1,10'h042,8'h33, 0,1,8'h7B);
    vecs[6]  = mk(0,10'h000,8'h00, 1,0,10'h013,8'h00, 1,10'h022, 0,1,0,1,0,10'h013,8'h00, 0,0,8'h00);
    vecs[7]  = mk(0,10'h000,8'h00, 1,1,10'h030,8'h77, 0,10'h000, 0,1,0,1,1,10'h030,8'h77, 1,0,8'h49);
    vecs[8]  = mk(0,10'h000,8'h00, 0,0,10'h000,8'h00, 1,10'h041, 0,0,1,1,0,10'h041,8'h00, 0,0,8'h00);
    vecs[9]  = mk(0,10'h000,8'h00, 0,0,10'h000,8'h00, 0,10'h000, 0,0,0,0,0,10'h000,8'h00, 0,1,8'h16);
    vecs[10] = mk(0,10'h000,8'h00, 1,0,10'h030,8'h00, 0,10'h000, 0,1,0,1,0,10'h030,8'h00, 0,0,8'h00);
    vecs[11] = mk(0,10'h000,8'h00, 0,0,10'h000,8'h00, 0,10'h000, 0,0,0,0,0,10'h000,8'h00, 1,0,8'h77);

    quiet();
    rst = 1; ram_init = 1;
    @(negedge clk);
    ram_init = 0;
    kb_req = 1; cpu_req = 1; vga_req = 1;
    #1;
    chk("reset.kb_gnt", kb_gnt, 0);
    chk("reset.cpu_gnt", cpu_gnt, 0);
    chk("reset.vga_gnt", vga_gnt, 0);
    chk("reset.mem_en", mem_en, 0);
    chk("reset.kb_busy", kb_busy, 0);
    @(negedge clk);
    quiet(); rst = 0;

    for (int i = 0; i < 12; i++) begin
      kb_req = vecs[i].kq; kb_addr = vecs[i].ka; kb_wdata = vecs[i].kd;
      cpu_req = vecs[i].cq; cpu_we = vecs[i].cw; cpu_addr = vecs[i].ca; cpu_wdata = vecs[i].cd;
      vga_req = vecs[i].vq; vga_addr = vecs[i].va;
      #1;
      chk($sformatf("v%0d.kb_gnt", i), kb_gnt, vecs[i].ekb);
      chk($sformatf("v%0d.cpu_gnt", i), cpu_gnt, vecs[i].ecpu);
      chk($sformatf("v%0d.vga_gnt", i), vga_gnt, vecs[i].evga);
      chk($sformatf("v%0d.mem_en", i), mem_en, vecs[i].een);
      if (vecs[i].een) begin
        chk($sformatf("v%0d.mem_we", i), mem_we, vecs[i].ewe);
        chk($sformatf("v%0d.mem_addr", i), mem_addr, vecs[i].eaddr);
        if (vecs[i].ewe) chk($sformatf("v%0d.mem_wdata", i), mem_wdata, vecs[i].ewd);
      end
      chk($sformatf("v%0d.cpu_rvalid", i), cpu_rvalid, vecs[i].ecrv);
      chk($sformatf("v%0d.vga_rvalid", i), vga_rvalid, vecs[i].evrv);
      if (vecs[i].ecrv) chk($sformatf("v%0d.cpu_rdata", i), cpu_rdata, vecs[i].erd);
      if (vecs[i].evrv) chk($sformatf("v%0d.vga_rdata", i), vga_rdata, vecs[i].erd);
      @(negedge clk);
    end
    quiet();

    // Uninterrupted line clear: 64 zero writes to 0x0C0..0x0FF, busy for 65 cycles.
    kb_req = 1; kb_clr = 1; kb_addr = 10'h0C5;
    #1;
    chk("clr.gnt", kb_gnt, 1);
    chk("clr.gnt_mem_en", mem_en, 0);
    chk("clr.gnt_busy", kb_busy, 1);
    busy_cycles = int'(kb_busy);
    @(negedge clk);
    quiet();
    for (int i = 0; i < 64; i++) begin
      #1;
      busy_cycles += int'(kb_busy);
      chk($sformatf("clr.w%0d.en_we", i), {mem_en, mem_we}, 2'b11);
      chk($sformatf("clr.w%0d.addr", i), mem_addr, 10'h0C0 + 10'(i));
      chk($sformatf("clr.w%0d.data", i), mem_wdata, 8'h00);
      @(negedge clk);
    end
    #1;
    chk("clr.end_busy", kb_busy, 0);
    chk("clr.end_mem_en", mem_en, 0);
    chk("clr.busy_cycles", busy_cycles, 65);
    for (int a = 'h0C0; a <= 'h0FF; a++) chk($sformatf("clr.ram%0h", a), ram[a], 8'h00);
    @(negedge clk);

    // Clear of line 0x100 pre-empted by 3 VGA reads; a plain keyboard write waits for it.
    kb_req = 1; kb_clr = 1; kb_addr = 10'h10A;
    #1;
    chk("pre.gnt", kb_gnt, 1);
    busy_cycles = int'(kb_busy);
    @(negedge clk);
    quiet();
    for (int i = 0; i < 67; i++) begin
      if (i >= 5 && i < 8) begin
        vga_req = 1; vga_addr = 10'h200;
      end else begin
        vga_req = 0;
      end
      if (i >= 6) begin
        kb_req = 1; kb_addr = 10'h300; kb_wdata = 8'h99;
      end
      #1;
      busy_cycles += int'(kb_busy);
      chk($sformatf("pre.c%0d.kb_gnt", i), kb_gnt, 0);
      if (i >= 5 && i < 8) begin
        chk($sformatf("pre.c%0d.vga_gnt", i), vga_gnt, 1);
        chk($sformatf("pre.c%0d.addr", i), mem_addr, 10'h200);
      end else begin
        chk($sformatf("pre.c%0d.clr_addr", i), mem_addr, 10'h100 + 10'(i < 5 ? i : i - 3));
        chk($sformatf("pre.c%0d.we", i), mem_we, 1);
      end
      @(negedge clk);
    end
    #1;
    chk("pre.end_busy", kb_busy, 0);
    chk("pre.kb_gnt_after", kb_gnt, 1);
    chk("pre.kb_addr_after", mem_addr, 10'h300);
    chk("pre.busy_cycles", busy_cycles, 68);
    @(negedge clk);
    quiet();

    // Reset after 10 clear writes, with a CPU read granted the cycle before reset.
    ram_init = 1;
    @(negedge clk);
    ram_init = 0;
    kb_req = 1; kb_clr = 1; kb_addr = 10'h0C5;
    @(negedge clk);
    quiet();
    repeat (10) @(negedge clk);
    cpu_req = 1; cpu_addr = 10'h123;
    #1;
    chk("rst.cpu_gnt", cpu_gnt, 1);
    @(negedge clk);
    quiet(); rst = 1;
    #1;
    chk("rst.cpu_rvalid", cpu_rvalid, 0);
    chk("rst.mem_en", mem_en, 0);
    chk("rst.kb_busy", kb_busy, 0);
    @(negedge clk);
    rst = 0;
    #1;
    chk("rst.after_busy", kb_busy, 0);
    chk("rst.after_mem_en", mem_en, 0);
    chk("rst.after_cpu_rvalid", cpu_rvalid, 0);
    for (int a = 'h0C0; a <= 'h0FF; a++)
      chk($sformatf("rst.ram%0h", a), ram[a], a < 'h0CA ? 8'h00 : 8'(a) ^ 8'h5A);
    @(negedge clk);
    cpu_req = 1; vga_req = 1; cpu_addr = 10'h001; vga_addr = 10'h002;
    #1;
    chk("rst.rr_cpu_first", {cpu_gnt, vga_gnt}, 2'b10);
    @(negedge clk);
    quiet();
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
